spi_target_core: RTL and testbench

- Single-lane SPI target (slave) engine: the far end of the SPI master core, for on-chip loopback and SoC-as-peripheral use.
- Oversamples sck/nss/mosi in the system clock domain, shifts 8-bit frames, drives miso.
- Exchanges bytes with TX/RX FIFOs over valid/ready handshakes; a register wrapper (APB4) sits above it.

---
 rtl/spi_target_core_pkg.sv | 27 ++
 rtl/spi_target_sync.sv | 30 +++
 rtl/spi_target_core.sv | 201 ++++++++++++++++++++
 tb/tb_spi_target_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_core_pkg.sv
// Shared SPI target definitions: FSM encoding, default dummy byte, latched config and shift helper.
package spi_target_core_pkg;

    localparam int unsigned SPI_TGT_BYTE_W = 8;
    localparam int unsigned SPI_TGT_CNT_W  = 3;

    localparam logic [0:0] SPI_TGT_IDLE = 1'b0;
    localparam logic [0:0] SPI_TGT_SEL  = 1'b1;

    localparam logic [SPI_TGT_BYTE_W-1:0] SPI_TGT_DUMMY_BYTE = 8'hFF;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb;
    } spi_tgt_cfg_t;

    // One-bit shift in the selected order; din enters at the end opposite the outgoing bit.
    function automatic logic [SPI_TGT_BYTE_W-1:0] spi_tgt_shift(
        input logic [SPI_TGT_BYTE_W-1:0] sr,
        input logic                      din,
        input logic                      lsb
    );
        return lsb ? {din, sr[SPI_TGT_BYTE_W-1:1]} : {sr[SPI_TGT_BYTE_W-2:0], din};
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// N-flop synchronizer with a history flop; rise/fall are combinational from the flops.
module spi_target_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o  = sync_q[STAGES-1];
    assign rise_c_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_c_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_target_core.sv
// Single-lane SPI target: oversampled bus, 8-bit frames, TX/RX valid/ready byte handshakes.
module spi_target_core
    import spi_target_core_pkg::*;
#(
    parameter int unsigned                 SYNC_STAGES = 2,
    parameter logic [SPI_TGT_BYTE_W-1:0]   DUMMY_BYTE  = SPI_TGT_DUMMY_BYTE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      cpol_i,
    input  logic                      cpha_i,
    input  logic                      lsb_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    input  logic [SPI_TGT_BYTE_W-1:0] tx_data_i,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic [SPI_TGT_BYTE_W-1:0] rx_data_o,
    output logic                      busy_o,
    output logic                      ovr_o,
    output logic                      udr_o,
    input  logic                      spi_sck_i,
    input  logic                      spi_nss_i,
    input  logic                      spi_mosi_i,
    output logic                      spi_miso_o,
    output logic                      spi_miso_en_o
);

    logic sck_lvl, sck_rise, sck_fall;
    logic nss_lvl, nss_rise, nss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i),
        .level_o(sck_lvl), .rise_c_o(sck_rise), .fall_c_o(sck_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_nss (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_nss_i),
        .level_o(nss_lvl), .rise_c_o(nss_rise), .fall_c_o(nss_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_mosi_i),
        .level_o(mosi_s), .rise_c_o(mosi_rise), .fall_c_o(mosi_fall)
    );

    logic unused_sync_bits;
    assign unused_sync_bits = ^{sck_lvl, nss_lvl, mosi_rise, mosi_fall};

    logic [0:0]                state_q, state_d;
    spi_tgt_cfg_t              cfg_q, cfg_d;
    logic [SPI_TGT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SPI_TGT_BYTE_W-1:0] rx_sr_q, rx_sr_d;
    logic [SPI_TGT_BYTE_W-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_TGT_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                      load_pend_q, load_pend_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      tx_ready_q, tx_ready_d;
    logic                      udr_q, udr_d;
    logic                      ovr_q, ovr_d;
    logic                      busy_q, busy_d;
    logic                      miso_q, miso_d;
    logic                      miso_en_q, miso_en_d;

    // Leading edge leaves the cpol level; cpha picks which edge samples.
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = cfg_q.cpol ? sck_fall : sck_rise;
    assign trail_edge  = cfg_q.cpol ? sck_rise : sck_fall;
    assign sample_edge = cfg_q.cpha ? trail_edge : lead_edge;
    assign shift_edge  = cfg_q.cpha ? lead_edge : trail_edge;

    logic tx_load, byte_done;

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        load_pend_d = load_pend_q;
        rx_valid_d  = rx_valid_q;
        tx_ready_d  = 1'b0;
        udr_d       = 1'b0;
        ovr_d       = 1'b0;
        tx_load     = 1'b0;
        byte_done   = 1'b0;

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            SPI_TGT_IDLE: begin
                if (en_i && nss_fall) begin
                    cfg_d.cpol  = cpol_i;
                    cfg_d.cpha  = cpha_i;
                    cfg_d.lsb   = lsb_i;
                    bit_cnt_d   = '0;
                    load_pend_d = 1'b0;
                    tx_load     = ~cpha_i;
                    state_d     = SPI_TGT_SEL;
                end
            end
            SPI_TGT_SEL: begin
                if (!en_i) begin
                    state_d = SPI_TGT_IDLE;
                end else begin
                    if (sample_edge) begin
                        rx_sr_d   = spi_tgt_shift(rx_sr_q, mosi_s, cfg_q.lsb);
                        bit_cnt_d = bit_cnt_q + SPI_TGT_CNT_W'(1);
                        if (bit_cnt_q == SPI_TGT_CNT_W'(7)) begin
                            byte_done   = 1'b1;
                            load_pend_d = ~cfg_q.cpha;
                        end
                    end
                    if (shift_edge) begin
                        if (cfg_q.cpha ? (bit_cnt_q == '0) : load_pend_q) begin
                            tx_load     = 1'b1;
                            load_pend_d = 1'b0;
                        end else begin
                            tx_sr_d = spi_tgt_shift(tx_sr_q, 1'b0, cfg_q.lsb);
                        end
                    end
                    // Sample above is kept even when the frame ends this cycle.
                    if (nss_rise) begin
                        state_d = SPI_TGT_IDLE;
                    end
                end
            end
            default: state_d = SPI_TGT_IDLE;
        endcase

        if (tx_load) begin
            if (tx_valid_i) begin
                tx_sr_d    = tx_data_i;
                tx_ready_d = 1'b1;
            end else begin
                tx_sr_d = DUMMY_BYTE;
                udr_d   = 1'b1;
            end
        end

        if (byte_done) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_d  = rx_sr_d;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d    = (state_d == SPI_TGT_SEL);
        miso_en_d = busy_d;
        miso_d    = busy_d & (cfg_d.lsb ? tx_sr_d[0] : tx_sr_d[SPI_TGT_BYTE_W-1]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SPI_TGT_IDLE;
            cfg_q       <= '0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_data_q   <= '0;
            load_pend_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            udr_q       <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
            miso_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            load_pend_q <= load_pend_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            udr_q       <= udr_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
            miso_en_q   <= miso_en_d;
        end
    end

    assign tx_ready_o    = tx_ready_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_data_o     = rx_data_q;
    assign busy_o        = busy_q;
    assign ovr_o         = ovr_q;
    assign udr_o         = udr_q;
    assign spi_miso_o    = miso_q;
    assign spi_miso_en_o = miso_en_q;

endmodule

// File: tb/tb_spi_target_core.sv
// Bench for spi_target_core: bit-banged SPI master, model TX FIFO, event counters and frame-level expectations.
module tb_spi_target_core;

    logic       clk = 1'b0;
    logic       rst_i, en_i, cpol_i, cpha_i, lsb_i;
    logic       tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
    logic [7:0] tx_data_i, rx_data_o;
    logic       busy_o, ovr_o, udr_o;
    logic       spi_sck_i, spi_nss_i, spi_mosi_i, spi_miso_o, spi_miso_en_o;

    spi_target_core dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_i(lsb_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
        .busy_o(busy_o), .ovr_o(ovr_o), .udr_o(udr_o),
        .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model TX FIFO: entries tx_mem[0..tx_n-1] are offered in order, popped on tx_ready_o.
    logic [7:0] tx_mem [4];
    logic [7:0] mo_mem [4];
    logic [7:0] mi_mem [4];
    int tx_base = 0;
    int tx_n    = 0;
    int tx_pops = 0;
    int tx_idx;
    assign tx_idx     = tx_pops - tx_base;
    assign tx_valid_i = (tx_idx < tx_n);
    assign tx_data_i  = tx_mem[tx_idx[1:0]];

    int n_txr = 0, n_udr = 0, n_ovr = 0, n_rxrise = 0, n_en = 0;
    logic rx_valid_prev = 1'b0;
    logic [7:0] rx_got [$];

    always @(negedge clk) begin
        if (tx_ready_o) begin
            n_txr   = n_txr + 1;
            tx_pops = tx_pops + 1;
        end
        if (udr_o) n_udr = n_udr + 1;
        if (ovr_o) n_ovr = n_ovr + 1;
        if (spi_miso_en_o) n_en = n_en + 1;
        if (rx_valid_o && !rx_valid_prev) n_rxrise = n_rxrise + 1;
        rx_valid_prev = rx_valid_o;
        if (rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic nss_low();
        spi_sck_i = cpol_i;
        clks(4);
        spi_nss_i = 1'b0;
        clks(8);
    endtask

    task automatic nss_high();
        clks(4);
        spi_nss_i = 1'b1;
        clks(12);
    endtask

    // Master side of n bits of byte k: drives mo_mem[k], captures miso into mi_mem[k].
    task automatic xfer_bits(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            int b;
            b = lsb_i ? i : 7 - i;
            if (!cpha_i) begin
                spi_mosi_i = mo_mem[k][b];
                clks(4);
                mi_mem[k][b] = spi_miso_o;
                spi_sck_i = ~cpol_i;
                clks(4);
                spi_sck_i = cpol_i;
            end else begin
                spi_sck_i = ~cpol_i;
                spi_mosi_i = mo_mem[k][b];
                clks(4);
                mi_mem[k][b] = spi_miso_o;
                spi_sck_i = cpol_i;
                clks(4);
            end
        end
    endtask

    // Full frame of nb bytes with ntx bytes queued; rx_ready_i held high.
    task automatic run_check(input string tag, input logic cp, input logic ph, input logic ls,
                             input int nb, input int ntx);
        int s_txr, s_udr, s_ovr, s_rise, s_rx, loads, e_txr;
        s_txr = n_txr; s_udr = n_udr; s_ovr = n_ovr; s_rise = n_rxrise; s_rx = rx_got.size();
        tx_base = tx_pops; tx_n = ntx;
        cpol_i = cp; cpha_i = ph; lsb_i = ls;
        nss_low();
        for (int k = 0; k < nb; k++) begin
            xfer_bits(k, 8);
            if (k == 0) begin
                chk({tag, "_busy"}, 32'(busy_o), 32'd1);
                chk({tag, "_misoen"}, 32'(spi_miso_en_o), 32'd1);
            end
        end
        nss_high();
        // One load per byte start, plus the cpha=0 load at select time.
        loads = ph ? nb : nb + 1;
        e_txr = (loads < ntx) ? loads : ntx;
        chk({tag, "_txready"}, 32'(n_txr - s_txr), 32'(e_txr));
        chk({tag, "_udr"}, 32'(n_udr - s_udr), 32'(loads - e_txr));
        chk({tag, "_ovr"}, 32'(n_ovr - s_ovr), 32'd0);
        chk({tag, "_rxrise"}, 32'(n_rxrise - s_rise), 32'(nb));
        chk({tag, "_rxcnt"}, 32'(rx_got.size() - s_rx), 32'(nb));
        for (int k = 0; k < nb; k++) begin
            chk($sformatf("%s_rx%0d", tag, k), 32'(rx_got[s_rx + k]), 32'(mo_mem[k]));
            chk($sformatf("%s_miso%0d", tag, k), 32'(mi_mem[k]),
                (k < ntx) ? 32'(tx_mem[k]) : 32'hFF);
        end
        chk({tag, "_idle"}, 32'({busy_o, spi_miso_en_o}), 32'd0);
    endtask

    initial begin
        int s_txr, s_udr, s_ovr, s_rise, s_rx, s_en;
        rst_i = 1'b1; en_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0;
        rx_ready_i = 1'b1;
        spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_mem[i] = 8'h00; mo_mem[i] = 8'h00; mi_mem[i] = 8'h00;
        end
        clks(3);
        chk("reset_outs", 32'({tx_ready_o, rx_valid_o, rx_data_o, busy_o, ovr_o, udr_o,
                              spi_miso_o, spi_miso_en_o}), 32'd0);
        rst_i = 1'b0;
        clks(6);

        // Mode 0 msb-first, one queued TX byte.
        tx_mem[0] = 8'hA5; mo_mem[0] = 8'h3C;
        run_check("m0", 1'b0, 1'b0, 1'b0, 1, 1);

        // Mode 3 lsb-first, back-to-back bytes, empty TX FIFO.
        mo_mem[0] = 8'h01; mo_mem[1] = 8'h80;
        run_check("m3", 1'b1, 1'b1, 1'b1, 2, 0);

        // Consumer stalled: second byte overruns, first byte held.
        rx_ready_i = 1'b0;
        s_ovr = n_ovr; s_rx = rx_got.size();
        cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; tx_base = tx_pops; tx_n = 0;
        mo_mem[0] = 8'h11; mo_mem[1] = 8'h22;
        nss_low(); xfer_bits(0, 8); xfer_bits(1, 8); nss_high();
        chk("ovr_data", 32'(rx_data_o), 32'h11);
        chk("ovr_valid", 32'(rx_valid_o), 32'd1);
        chk("ovr_pulses", 32'(n_ovr - s_ovr), 32'd1);
        rx_ready_i = 1'b1;
        clks(3);
        chk("ovr_drain_valid", 32'(rx_valid_o), 32'd0);
        chk("ovr_drain_cnt", 32'(rx_got.size() - s_rx), 32'd1);
        chk("ovr_drain_data", 32'(rx_got[s_rx]), 32'h11);

        // Frame aborted after 5 bits, then a clean frame.
        s_rise = n_rxrise; s_ovr = n_ovr; s_rx = rx_got.size();
        mo_mem[0] = 8'hFF;
        nss_low(); xfer_bits(0, 5); nss_high();
        chk("abort_rxrise", 32'(n_rxrise - s_rise), 32'd0);
        chk("abort_ovr", 32'(n_ovr - s_ovr), 32'd0);
        chk("abort_rxcnt", 32'(rx_got.size() - s_rx), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        mo_mem[0] = 8'h5A;
        run_check("after_abort", 1'b0, 1'b0, 1'b0, 1, 0);

        // Reset in the middle of a byte.
        mo_mem[0] = 8'hF0;
        nss_low(); xfer_bits(0, 4);
        rst_i = 1'b1;
        clks(1);
        chk("midrst_outs", 32'({tx_ready_o, rx_valid_o, rx_data_o, busy_o, ovr_o, udr_o,
                               spi_miso_o, spi_miso_en_o}), 32'd0);
        spi_nss_i = 1'b1;
        clks(3);
        chk("midrst_hold", 32'({rx_valid_o, busy_o, spi_miso_en_o}), 32'd0);
        rst_i = 1'b0;
        clks(6);
        mo_mem[0] = 8'hC3; tx_mem[0] = 8'h96;
        run_check("after_rst", 1'b0, 1'b1, 1'b0, 1, 1);

        // Disabled core ignores a full frame.
        en_i = 1'b0;
        s_txr = n_txr; s_udr = n_udr; s_ovr = n_ovr; s_rise = n_rxrise; s_en = n_en;
        s_rx = rx_got.size();
        cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; tx_base = tx_pops; tx_n = 1;
        mo_mem[0] = 8'h77;
        nss_low(); xfer_bits(0, 8);
        chk("dis_misoen_mid", 32'(spi_miso_en_o), 32'd0);
        nss_high();
        chk("dis_en_cycles", 32'(n_en - s_en), 32'd0);
        chk("dis_pulses", 32'((n_txr - s_txr) + (n_udr - s_udr) + (n_ovr - s_ovr)), 32'd0);
        chk("dis_rx", 32'((n_rxrise - s_rise) + (rx_got.size() - s_rx)), 32'd0);
        en_i = 1'b1;
        clks(4);
        mo_mem[0] = 8'hE7; tx_mem[0] = 8'h42;
        run_check("reenable", 1'b0, 1'b0, 1'b1, 1, 1);

        // Randomized frames across modes, lengths and TX fill levels.
        for (int r = 0; r < 5; r++) begin
            logic cp, ph, ls;
            int nb, ntx;
            cp = 1'($urandom_range(0, 1));
            ph = 1'($urandom_range(0, 1));
            ls = 1'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 3));
            ntx = int'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                mo_mem[i] = 8'($urandom);
                tx_mem[i] = 8'($urandom);
            end
            run_check($sformatf("rnd%0d", r), cp, ph, ls, nb, ntx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
